// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - watch timekeeper: 1 Hz prescaler, sec/min/hr counters, two-button set UI (optional 12-hour view via TK_HOUR12_EN)
module time_keeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       Button1Tk,
  input  logic       Button2Tk,
  output logic [5:0] SecTk,
  output logic [5:0] MinTk,
  output logic [4:0] HrTk,
  output logic [1:0] BlinkTk,
  output logic       SecPulse
`ifdef TK_HOUR12_EN
  ,
  output logic [3:0] HrDisp,
  output logic       PmBit
`endif
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_HR  = 2'd2
  } mode_e;

  mode_e         mode_q;
  logic          b1_prev_q, b2_prev_q;
  logic          b1_rise, b2_rise;
  logic          tick, enter_set;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic          pulse_q, pulse_d;

  assign b1_rise   = Button1Tk & ~b1_prev_q;
  assign b2_rise   = Button2Tk & ~b2_prev_q;
  assign tick      = (pre_q == PRE_LAST) && (mode_q == MODE_RUN);
  assign enter_set = b1_rise && (mode_q == MODE_RUN);

  // Remember last button levels so a held button yields a single rise event
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      b1_prev_q <= 1'b0;
      b2_prev_q <= 1'b0;
    end else begin
      b1_prev_q <= Button1Tk;
      b2_prev_q <= Button2Tk;
    end
  end

  // Set-mode FSM: each mode-button rise steps run -> minutes -> hours -> run
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      mode_q <= MODE_RUN;
    end else if (b1_rise) begin
      case (mode_q)
        MODE_RUN:     mode_q <= MODE_SET_MIN;
        MODE_SET_MIN: mode_q <= MODE_SET_HR;
        default:      mode_q <= MODE_RUN;
      endcase
    end
  end

  // Next-state for prescaler, time counters and second strobe
  always_comb begin
    pre_d   = pre_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pulse_d = 1'b0;

    // Prescaler sits at 0 throughout set mode so the first run second is a full one
    if ((mode_q != MODE_RUN) || enter_set || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    if (enter_set) begin
      // Mode change wins over a coincident tick: seconds restart from zero
      sec_d = 6'd0;
    end else if (tick) begin
      pulse_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (b2_rise && !b1_rise) begin
      // Increment only the selected field; no carry between fields while setting
      case (mode_q)
        MODE_SET_MIN: min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        MODE_SET_HR:  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        default:      ;
      endcase
    end
  end

  // Time state registers
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      pre_q   <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 5'd0;
      pulse_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pulse_q <= pulse_d;
    end
  end

  assign SecTk    = sec_q;
  assign MinTk    = min_q;
  assign HrTk     = hr_q;
  assign BlinkTk  = mode_q;
  assign SecPulse = pulse_q;

`ifdef TK_HOUR12_EN
  logic [4:0] h12;

  // 12-hour view derived from the 24-hour count; midnight and noon show 12
  always_comb begin
    h12 = hr_q;
    if (hr_q >= 5'd12) begin
      h12 = hr_q - 5'd12;
    end
    if (h12 == 5'd0) begin
      h12 = 5'd12;
    end
    HrDisp = 4'(h12);
    PmBit  = (hr_q >= 5'd12);
  end
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper with TICK_DIV=4
module tb_time_keeper;

  logic       Clk;
  logic       RstN;
  logic       Button1Tk;
  logic       Button2Tk;
  logic [5:0] SecTk;
  logic [5:0] MinTk;
  logic [4:0] HrTk;
  logic [1:0] BlinkTk;
  logic       SecPulse;
`ifdef TK_HOUR12_EN
  logic [3:0] HrDisp;
  logic       PmBit;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  time_keeper #(.TICK_DIV(4)) dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .Button1Tk (Button1Tk),
    .Button2Tk (Button2Tk),
    .SecTk     (SecTk),
    .MinTk     (MinTk),
    .HrTk      (HrTk),
    .BlinkTk   (BlinkTk),
    .SecPulse  (SecPulse)
`ifdef TK_HOUR12_EN
    ,
    .HrDisp    (HrDisp),
    .PmBit     (PmBit)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic run_cycles(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (SecPulse) pulses++;
    end
  endtask

  task automatic press1();
    Button1Tk = 1'b1;
    cyc(1);
    Button1Tk = 1'b0;
    cyc(1);
  endtask

  task automatic press2(input int n);
    for (int i = 0; i < n; i++) begin
      Button2Tk = 1'b1;
      cyc(1);
      Button2Tk = 1'b0;
      cyc(1);
    end
  endtask

  task automatic chk_time(input string name, input logic [5:0] h, input logic [5:0] m,
                          input logic [5:0] s);
    total_cnt++;
    if ({1'b0, HrTk} !== h || MinTk !== m || SecTk !== s)
      $display("FAIL %s: got %0d:%0d:%0d want %0d:%0d:%0d", name, HrTk, MinTk, SecTk, h, m, s);
    else
      pass_cnt++;
  endtask

  task automatic do_reset();
    RstN      = 1'b0;
    Button1Tk = 1'b0;
    Button2Tk = 1'b0;
    cyc(2);
    RstN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    chk_time("reset_time", 6'd0, 6'd0, 6'd0);
    total_cnt++;
    if (BlinkTk !== 2'd0 || SecPulse !== 1'b0)
      $display("FAIL reset_ctrl: blink=%0d pulse=%0b want 0/0", BlinkTk, SecPulse);
    else pass_cnt++;
  endtask

  task automatic test_first_tick();
    int p;
    run_cycles(3, p);
    total_cnt++;
    if (SecTk !== 6'd0 || p != 0)
      $display("FAIL pre_tick: sec=%0d pulses=%0d want 0/0", SecTk, p);
    else pass_cnt++;
    cyc(1);
    total_cnt++;
    if (SecTk !== 6'd1 || SecPulse !== 1'b1)
      $display("FAIL first_tick: sec=%0d pulse=%0b want 1/1", SecTk, SecPulse);
    else pass_cnt++;
    cyc(1);
    total_cnt++;
    if (SecPulse !== 1'b0)
      $display("FAIL pulse_width: pulse=%0b want 0", SecPulse);
    else pass_cnt++;
    cyc(235);
    chk_time("one_minute", 6'd0, 6'd1, 6'd0);
  endtask

  task automatic test_rollover();
    int p;
    do_reset();
    press1();
    press2(59);
    press1();
    press2(23);
    chk_time("preload", 6'd23, 6'd59, 6'd0);
    Button1Tk = 1'b1;
    cyc(1);
    Button1Tk = 1'b0;
    total_cnt++;
    if (BlinkTk !== 2'd0)
      $display("FAIL exit_set: blink=%0d want 0", BlinkTk);
    else pass_cnt++;
    cyc(236);
    chk_time("pre_midnight", 6'd23, 6'd59, 6'd59);
    run_cycles(4, p);
    chk_time("midnight", 6'd0, 6'd0, 6'd0);
    total_cnt++;
    if (p != 1 || SecPulse !== 1'b1)
      $display("FAIL midnight_pulse: pulses=%0d last=%0b want 1/1", p, SecPulse);
    else pass_cnt++;
  endtask

  task automatic test_set_entry();
    int p;
    run_cycles(28, p);
    chk_time("run_to_7", 6'd0, 6'd0, 6'd7);
    Button1Tk = 1'b1;
    cyc(1);
    total_cnt++;
    if (BlinkTk !== 2'd1 || SecTk !== 6'd0)
      $display("FAIL enter_set: blink=%0d sec=%0d want 1/0", BlinkTk, SecTk);
    else pass_cnt++;
    cyc(9);
    total_cnt++;
    if (BlinkTk !== 2'd1)
      $display("FAIL held_button: blink=%0d want 1", BlinkTk);
    else pass_cnt++;
    Button1Tk = 1'b0;
    run_cycles(20, p);
    total_cnt++;
    if (p != 0 || SecTk !== 6'd0 || BlinkTk !== 2'd1)
      $display("FAIL frozen: pulses=%0d sec=%0d blink=%0d want 0/0/1", p, SecTk, BlinkTk);
    else pass_cnt++;
  endtask

  task automatic test_increment();
    press1();
    press2(23);
    chk_time("hr_23", 6'd23, 6'd0, 6'd0);
    press2(1);
    chk_time("hr_wrap", 6'd0, 6'd0, 6'd0);
    press2(5);
    press1();
    press2(1);
    total_cnt++;
    if (BlinkTk !== 2'd0 || HrTk !== 5'd5 || MinTk !== 6'd0)
      $display("FAIL run_ignore: blink=%0d hr=%0d min=%0d want 0/5/0", BlinkTk, HrTk, MinTk);
    else pass_cnt++;
    press1();
    press2(59);
    chk_time("min_59", 6'd5, 6'd59, 6'd0);
    press2(1);
    chk_time("min_wrap_nocarry", 6'd5, 6'd0, 6'd0);
  endtask

  task automatic test_simultaneous();
    press2(3);
    Button1Tk = 1'b1;
    Button2Tk = 1'b1;
    cyc(1);
    Button1Tk = 1'b0;
    Button2Tk = 1'b0;
    cyc(1);
    total_cnt++;
    if (BlinkTk !== 2'd2 || MinTk !== 6'd3 || HrTk !== 5'd5)
      $display("FAIL simultaneous: blink=%0d min=%0d hr=%0d want 2/3/5", BlinkTk, MinTk, HrTk);
    else pass_cnt++;
  endtask

  task automatic test_mid_set_reset();
    RstN = 1'b0;
    cyc(1);
    RstN = 1'b1;
    chk_time("midset_reset_time", 6'd0, 6'd0, 6'd0);
    total_cnt++;
    if (BlinkTk !== 2'd0 || SecPulse !== 1'b0)
      $display("FAIL midset_reset_ctrl: blink=%0d pulse=%0b want 0/0", BlinkTk, SecPulse);
    else pass_cnt++;
  endtask

`ifdef TK_HOUR12_EN
  task automatic test_hour12();
    do_reset();
    total_cnt++;
    if (HrDisp !== 4'd12 || PmBit !== 1'b0)
      $display("FAIL h12_0: disp=%0d pm=%0b want 12/0", HrDisp, PmBit);
    else pass_cnt++;
    press1();
    press1();
    press2(12);
    total_cnt++;
    if (HrDisp !== 4'd12 || PmBit !== 1'b1)
      $display("FAIL h12_12: disp=%0d pm=%0b want 12/1", HrDisp, PmBit);
    else pass_cnt++;
    press2(1);
    total_cnt++;
    if (HrDisp !== 4'd1 || PmBit !== 1'b1)
      $display("FAIL h12_13: disp=%0d pm=%0b want 1/1", HrDisp, PmBit);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_tick();
    test_rollover();
    test_set_entry();
    test_increment();
    test_simultaneous();
    test_mid_set_reset();
`ifdef TK_HOUR12_EN
    test_hour12();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
